// File: rtl/obuff_drain_pkg.sv
// Shared types and helpers for the obuff drain controller.
package obuff_drain_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StFlush,
    StFinish
  } drain_state_e;

  // Two entries cover the one-cycle read latency plus one stalled word.
  localparam int unsigned DRAIN_FIFO_DEPTH     = 2;
  localparam int unsigned DRAIN_FIFO_CNT_WIDTH = $clog2(DRAIN_FIFO_DEPTH + 1);

  // Address increment that wraps to zero for any cell count, power of two or not.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned count);
    return (addr + 1 >= count) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry fall-through FIFO that absorbs obuff read responses under backpressure.
// When empty, a word being pushed is visible at the head in the same cycle.
module drain_skid_fifo
  import obuff_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_push,
  input  logic [DATA_WIDTH-1:0]           i_push_data,
  input  logic                            i_pop,
  input  logic                            i_flush,
  output logic [DRAIN_FIFO_CNT_WIDTH-1:0] o_count,
  output logic [DATA_WIDTH-1:0]           o_head
);

  localparam int unsigned PTR_WIDTH = $clog2(DRAIN_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]           r_mem [DRAIN_FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]            r_wr_ptr;
  logic [PTR_WIDTH-1:0]            r_rd_ptr;
  logic [DRAIN_FIFO_CNT_WIDTH-1:0] r_count;

  logic w_empty;
  logic w_store;
  logic w_take;

  // A push popped straight through an empty FIFO is never stored.
  always_comb begin
    w_empty = (r_count == '0);
    w_store = i_push & ~(i_pop & w_empty);
    w_take  = i_pop & ~w_empty;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_take)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + DRAIN_FIFO_CNT_WIDTH'(w_store) - DRAIN_FIFO_CNT_WIDTH'(w_take);
    end
  end

  // Storage array; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_store && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Head selection: stored word first, then bypass of an incoming word, else zero.
  always_comb begin
    o_count = r_count;
    if (!w_empty)    o_head = r_mem[r_rd_ptr];
    else if (i_push) o_head = i_push_data;
    else             o_head = '0;
  end

endmodule

// File: rtl/obuff_drain_controller.sv
// Drains a contiguous obuff region onto a valid/ready stream, hiding the
// one-cycle obuff read latency with a credit-limited two-entry skid FIFO.
module obuff_drain_controller
  import obuff_drain_pkg::*;
#(
  parameter int unsigned OBUFF_CELL_COUNT = 4096,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT),
  parameter int unsigned LEN_WIDTH        = OBUFF_ADDR_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [OBUFF_ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]        drain_len,
  output logic                        obuff_r_en,
  output logic [OBUFF_ADDR_WIDTH-1:0] obuff_r_addr,
  input  logic [DATA_WIDTH-1:0]       obuff_r_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned OCC_WIDTH = DRAIN_FIFO_CNT_WIDTH + 1;

  drain_state_e                  r_state;
  logic [OBUFF_ADDR_WIDTH-1:0]   r_rd_addr;
  logic [LEN_WIDTH-1:0]          r_issue_rem;
  logic [LEN_WIDTH-1:0]          r_pop_rem;
  logic                          r_inflight;
  logic                          r_zero_len;
  logic                          r_done;

  logic [DRAIN_FIFO_CNT_WIDTH-1:0] w_fifo_count;
  logic [DATA_WIDTH-1:0]           w_fifo_head;
  logic [OCC_WIDTH-1:0]            w_occ_after;
  logic                            w_abort;
  logic                            w_pop;
  logic                            w_push;
  logic                            w_issue;

  // Credit check: words held or in flight, minus this cycle's pop, must leave room.
  always_comb begin
    w_abort     = abort & (r_state != StIdle);
    m_valid     = (w_fifo_count != '0) | r_inflight;
    w_pop       = m_valid & m_ready & ~w_abort;
    w_push      = r_inflight & ~w_abort;
    w_occ_after = {1'b0, w_fifo_count} + OCC_WIDTH'(r_inflight) - OCC_WIDTH'(w_pop);
    w_issue     = (r_state == StRead) & ~w_abort & (r_issue_rem != '0) &
                  (w_occ_after < OCC_WIDTH'(DRAIN_FIFO_DEPTH));
  end

  // Output decode from registered state and FIFO head.
  always_comb begin
    obuff_r_en   = w_issue;
    obuff_r_addr = r_rd_addr;
    m_data       = w_fifo_head;
    m_last       = m_valid & (r_pop_rem == LEN_WIDTH'(1));
    busy         = (r_state != StIdle);
    done         = r_done;
  end

  // FSM with address, issue/pop counters and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rd_addr   <= '0;
      r_issue_rem <= '0;
      r_pop_rem   <= '0;
      r_inflight  <= 1'b0;
      r_zero_len  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= 1'b0;
      if (w_issue) begin
        r_rd_addr   <= OBUFF_ADDR_WIDTH'(wrap_inc(32'(r_rd_addr), OBUFF_CELL_COUNT));
        r_issue_rem <= r_issue_rem - LEN_WIDTH'(1);
      end
      if (w_pop) r_pop_rem <= r_pop_rem - LEN_WIDTH'(1);

      if (w_abort) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (start) begin
              r_rd_addr   <= start_addr;
              r_issue_rem <= drain_len;
              r_pop_rem   <= drain_len;
              r_zero_len  <= (drain_len == '0);
              r_state     <= (drain_len == '0) ? StFinish : StRead;
            end
          end
          StRead: begin
            if (w_issue && r_issue_rem == LEN_WIDTH'(1)) r_state <= StFlush;
          end
          StFlush: begin
            // done follows the final handshake by exactly one cycle.
            if (w_pop && r_pop_rem == LEN_WIDTH'(1)) begin
              r_state <= StFinish;
              r_done  <= 1'b1;
            end
          end
          StFinish: begin
            // Zero-length drains have no handshake, so their done pulse is issued here.
            r_state <= StIdle;
            r_done  <= r_zero_len;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  drain_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(obuff_r_data),
    .i_pop      (w_pop),
    .i_flush    (w_abort),
    .o_count    (w_fifo_count),
    .o_head     (w_fifo_head)
  );

endmodule

// File: tb/tb_obuff_drain_controller.sv
// Randomized bench for obuff_drain_controller with a stream-level reference model.
module tb_obuff_drain_controller;

  localparam int CELLS = 4096;
  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int LW    = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] drain_len;
  logic          obuff_r_en;
  logic [AW-1:0] obuff_r_addr;
  logic [DW-1:0] obuff_r_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  obuff_drain_controller #(
    .OBUFF_CELL_COUNT(CELLS),
    .DATA_WIDTH      (DW),
    .OBUFF_ADDR_WIDTH(AW),
    .LEN_WIDTH       (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .start_addr  (start_addr),
    .drain_len   (drain_len),
    .obuff_r_en  (obuff_r_en),
    .obuff_r_addr(obuff_r_addr),
    .obuff_r_data(obuff_r_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] salt;

  function automatic logic [15:0] exp_data(input int a);
    return 16'(a % CELLS) ^ salt;
  endfunction

  // Synchronous obuff model: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (obuff_r_en) obuff_r_data <= exp_data(int'(obuff_r_addr));
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stream-level model state, owned by the monitor.
  bit          mon_en = 1'b0;
  int          n_iss, n_pop, n_done, n_busy;
  int          t0, cur_start, cur_len;
  int          first_ren, first_val, done_cyc, last_pop, t_abort;
  bit          aborted, held, ren_low_stall;
  logic [15:0] held_data;

  // Monitor: samples on the falling edge, compares against the address/data sequence.
  always @(negedge clk) begin
    if (mon_en) begin
      if (start && !busy) begin
        n_iss = 0; n_pop = 0; n_done = 0; n_busy = 0;
        t0 = cyc; cur_start = int'(start_addr); cur_len = int'(drain_len);
        first_ren = -1; first_val = -1; done_cyc = -1; last_pop = -1; t_abort = -1;
        aborted = 0; held = 0; ren_low_stall = 0;
      end else begin
        if (busy) n_busy++;
        if (abort && busy) check("abort_ren", 32'(obuff_r_en), 0);
        if (obuff_r_en) begin
          check("raddr", 32'(obuff_r_addr), 32'((cur_start + n_iss) % CELLS));
          check("over_issue", 32'(n_iss < cur_len), 1);
          if (first_ren < 0) first_ren = cyc;
          n_iss++;
        end
        if (m_valid && first_val < 0) first_val = cyc;
        if (held) begin
          check("hold_valid", 32'(m_valid), 1);
          check("hold_data", 32'(m_data), 32'(held_data));
        end
        if (m_valid) check("last", 32'(m_last), 32'(n_pop == cur_len - 1));
        else         check("last_idle", 32'(m_last), 0);
        if (m_valid && m_ready && !abort) begin
          check("data", 32'(m_data), 32'(exp_data(cur_start + n_pop)));
          n_pop++;
          last_pop = cyc;
        end
        if (!aborted) check("credit", 32'((n_iss - n_pop) <= 2), 1);
        held      = m_valid && !m_ready && !abort;
        held_data = m_data;
        if (m_valid && !m_ready && !obuff_r_en && n_iss < cur_len) ren_low_stall = 1;
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (aborted && cyc == t_abort + 1) begin
          check("abort_busy", 32'(busy), 0);
          check("abort_valid", 32'(m_valid), 0);
        end
        if (abort && busy && !aborted) begin
          aborted = 1;
          t_abort = cyc;
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ren"}, 32'(obuff_r_en), 0);
    check({tag, "_raddr"}, 32'(obuff_r_addr), 0);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_data"}, 32'(m_data), 0);
    check({tag, "_last"}, 32'(m_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // mode: 0 ready high, 1 stall word 2 for 5 cycles, 2 random ready.
  task automatic run_drain(input int addr, input int len, input int mode, input int abort_after);
    int  stall;
    bit  fin;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = AW'(addr);
    drain_len  = LW'(len);
    m_ready    = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = AW'($urandom);
    drain_len  = LW'($urandom);
    stall      = 0;
    fin        = 0;
    for (int c = 0; c < len * 8 + 40 && !fin; c++) begin
      abort = 1'b0;
      case (mode)
        0: m_ready = 1'b1;
        1: begin
          if (n_pop >= 2 && stall < 5) begin
            m_ready = 1'b0;
            stall++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_after >= 0 && !aborted && n_pop == abort_after) abort = 1'b1;
      @(posedge clk); #1;
      if (done_cyc >= 0 && cyc > done_cyc + 1) fin = 1;
      if (aborted && cyc > t_abort + 3) fin = 1;
    end
    abort   = 1'b0;
    m_ready = 1'b1;
    check("timeout", 32'(fin), 1);
    if (abort_after >= 0) begin
      check("abort_seen", 32'(aborted), 1);
      check("abort_no_done", 32'(n_done), 0);
      check("abort_words", 32'(n_pop), 32'(abort_after));
    end else begin
      check("done_count", 32'(n_done), 1);
      check("words", 32'(n_pop), 32'(len));
      check("issues", 32'(n_iss), 32'(len));
      if (len > 0) begin
        check("lat_ren", 32'(first_ren - t0), 1);
        check("lat_valid", 32'(first_val - t0), 2);
        check("lat_done", 32'(done_cyc - last_pop), 1);
        if (mode == 0) check("done_abs", 32'(done_cyc - t0), 32'(len + 2));
        if (mode == 1) check("stall_ren_low", 32'(ren_low_stall), 1);
      end else begin
        check("zero_done", 32'(done_cyc - t0), 2);
        check("zero_busy", 32'(n_busy), 1);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    start_addr = '0;
    drain_len  = '0;
    m_ready    = 1'b0;
    salt       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Basic drain with data equal to address.
    run_drain(10, 4, 0, -1);
    salt = 16'($urandom);
    run_drain(4094, 4, 0, -1);
    run_drain(int'($urandom_range(0, CELLS - 1)), 8, 1, -1);
    run_drain(int'($urandom_range(0, CELLS - 1)), 0, 0, -1);
    run_drain(int'($urandom_range(0, CELLS - 1)), 16, 0, 5);
    run_drain(100, 2, 0, -1);
    for (int i = 0; i < 4; i++) begin
      salt = 16'($urandom);
      run_drain(int'($urandom_range(0, CELLS - 1)), int'($urandom_range(1, 40)), 2, -1);
    end

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 12'd200;
    drain_len  = 13'd64;
    m_ready    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Full-buffer drain under random backpressure.
    salt = 16'($urandom);
    run_drain(int'($urandom_range(0, CELLS - 1)), CELLS, 2, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
